// File: rtl/truth_table_sweeper.sv
// Sequential truth-table characteriser for a 4-input combinational netlist:
// walks rows 0..15, settles, captures the synchronised output and grades the table.
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h1714
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_out,
  output logic        drive_in1,
  output logic        drive_in2,
  output logic        drive_in3,
  output logic        drive_in4,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        pass,
  output logic [4:0]  mismatch_cnt
);

  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 3..255");
  end

  localparam logic [7:0] SC_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [3:0]  row;
  logic [7:0]  sc;
  logic        sync1, sync2;
  logic [15:0] tt_final;
  logic [15:0] diff;
  logic [4:0]  pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= dut_out;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (sc == SC_LAST) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        state_next = (row == 4'd15) ? DONE : SETTLE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Table including the bit being captured this cycle, so the final grade
  // can be registered on the CAPTURE->DONE edge and is valid while done is high.
  always_comb begin
    tt_final              = tt;
    tt_final[4'd15 - row] = sync2;
    diff                  = tt_final ^ EXPECTED;
    pop                   = '0;
    for (int unsigned i = 0; i < 16; i++) pop = pop + 5'(diff[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row          <= '0;
      sc           <= '0;
      tt           <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row          <= '0;
            sc           <= '0;
            tt           <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
          end
        end
        SETTLE:  sc <= sc + 8'd1;
        CAPTURE: begin
          tt <= tt_final;
          if (row == 4'd15) begin
            pass         <= (tt_final == EXPECTED);
            mismatch_cnt <= pop;
          end else begin
            row <= row + 4'd1;
            sc  <= '0;
          end
        end
        DONE:    row <= '0;
        default: row <= '0;
      endcase
    end
  end

  assign {drive_in1, drive_in2, drive_in3, drive_in4} = row;

endmodule
